// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: req/ack handshake, fixed LATENCY, pipeline stall.
// Optional build macro MISALIGN_CHECK_EN flags and suppresses misaligned accesses via err_o.
//
// state | meaning
// IDLE  | waiting for req_i; latches request fields on accept
// BUSY  | counting down latency; access performed when cnt reaches 0
// RESP  | one-cycle ack_o (and err_o) pulse, then back to IDLE
module data_mem_responder #(
  parameter int DEPTH_LOG2 = 5,
  parameter int LATENCY    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [3:0]            r_cnt;
  logic [3:0]            w_cnt_nxt;
  logic                  r_we;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic                  r_mis;
  logic                  r_ack;
  logic                  r_err;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [2**DEPTH_LOG2];
  logic                  w_accept;
  logic                  w_done;
  logic                  w_misalign;
  logic                  w_unused_addr;

`ifdef MISALIGN_CHECK_EN
  assign w_misalign = (addr_i[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  // Upper address bits wrap by design; byte-lane bits only matter with the check enabled.
  assign w_unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          w_accept    = 1'b1;
          w_cnt_nxt   = 4'(LATENCY - 1);
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_done      = 1'b1;
          w_state_nxt = RESP;
        end
      end
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= 32'd0;
      r_mis   <= 1'b0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ack   <= w_done;
      r_err   <= w_done & r_mis;
      if (w_accept) begin
        r_we    <= we_i;
        r_idx   <= addr_i[DEPTH_LOG2+1:2];
        r_wdata <= wdata_i;
        r_mis   <= w_misalign;
      end
      if (w_done && !r_we && !r_mis) begin
        r_rdata <= r_mem[r_idx];
      end
    end
  end

  // Array is deliberately not reset; a reset mid-access leaves the FSM in IDLE so no write fires.
  always_ff @(posedge clk_i) begin
    if (w_done && r_we && !r_mis) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign stall_o = ((r_state == IDLE) && req_i) || (r_state == BUSY);
  assign ack_o   = r_ack;
  assign err_o   = r_err;
  assign rdata_o = r_rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed-vector bench for data_mem_responder (LATENCY=3, DEPTH_LOG2=5).
// Expectations follow the MISALIGN_CHECK_EN setting of the build.
module tb_data_mem_responder;

  localparam int LAT = 3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [31:0] addr_i = 32'd0;
  logic [31:0] wdata_i = 32'd0;
  logic        stall_o;
  logic        ack_o;
  logic [31:0] rdata_o;
  logic        err_o;

  int vectors = 0;
  int miscompares = 0;

  data_mem_responder #(.DEPTH_LOG2(5), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .stall_o(stall_o),
    .ack_o(ack_o), .rdata_o(rdata_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  // Starts just after a rising edge with the DUT in IDLE; returns the same way.
  // Request fields are scrambled after acceptance to prove they are sampled only in IDLE.
  task automatic access(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output logic er);
    int got;
    got = -1;
    rd = 32'hX;
    er = 1'bX;
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
    @(negedge clk_i);
    vectors++;
    if (stall_o !== 1'b1) begin
      miscompares++;
      $display("FAIL %s req-cycle stall: got %b want 1", name, stall_o);
    end
    @(posedge clk_i); #1;
    we_i = ~we; addr_i = ~addr; wdata_i = ~wdata;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (ack_o === 1'b1) begin
        got = k;
        rd = rdata_o;
        er = err_o;
        vectors++;
        if (stall_o !== 1'b0) begin
          miscompares++;
          $display("FAIL %s ack-cycle stall: got %b want 0", name, stall_o);
        end
        break;
      end
      vectors++;
      if (stall_o !== 1'b1) begin
        miscompares++;
        $display("FAIL %s busy stall cycle %0d: got %b want 1", name, k, stall_o);
      end
    end
    req_i = 1'b0;
    vectors++;
    if (got != LAT) begin
      miscompares++;
      $display("FAIL %s ack latency: got %0d want %0d", name, got, LAT);
    end
    @(negedge clk_i);
    vectors++;
    if (ack_o !== 1'b0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s post-ack: ack %b err %b want 0 0", name, ack_o, err_o);
    end
    @(posedge clk_i); #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      vectors++;
      if (stall_o !== 1'b0 || ack_o !== 1'b0 || rdata_o !== 32'd0 || err_o !== 1'b0) begin
        miscompares++;
        $display("FAIL idle %0d: stall %b ack %b rdata %h err %b want 0 0 0 0",
                 i, stall_o, ack_o, rdata_o, err_o);
      end
    end
    @(posedge clk_i); #1;
  endtask

  task automatic test_store_load();
    logic [31:0] rd;
    logic er;
    access("store10", 1'b1, 32'h10, 32'hDEADBEEF, rd, er);
    check_val("store10 err", {31'd0, er}, 32'd0);
    check_val("store10 rdata", rd, 32'd0);
    access("load10", 1'b0, 32'h10, 32'h0, rd, er);
    check_val("load10 rdata", rd, 32'hDEADBEEF);
    check_val("load10 err", {31'd0, er}, 32'd0);
    access("store14", 1'b1, 32'h14, 32'h11111111, rd, er);
    check_val("store14 rdata held", rd, 32'hDEADBEEF);
    check_val("rdata held idle", rdata_o, 32'hDEADBEEF);
    access("load14", 1'b0, 32'h14, 32'h0, rd, er);
    check_val("load14 rdata", rd, 32'h11111111);
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    logic er;
    access("store84", 1'b1, 32'h84, 32'h12345678, rd, er);
    access("load04", 1'b0, 32'h04, 32'h0, rd, er);
    check_val("wrap load04", rd, 32'h12345678);
    access("load10 again", 1'b0, 32'hFFFF_FF90, 32'h0, rd, er);
    check_val("wrap loadFFFFFF90", rd, 32'hDEADBEEF);
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd;
    logic er;
    access("store20", 1'b1, 32'h20, 32'h0BADF00D, rd, er);
    access("load20", 1'b0, 32'h20, 32'h0, rd, er);
    check_val("load20 prior", rd, 32'h0BADF00D);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'hA5A5A5A5;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0; req_i = 1'b0;
    #1;
    vectors++;
    if (stall_o !== 1'b0 || ack_o !== 1'b0 || rdata_o !== 32'd0 || err_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset-abort outputs: stall %b ack %b rdata %h err %b want 0 0 0 0",
               stall_o, ack_o, rdata_o, err_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      vectors++;
      if (ack_o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset-abort ack %0d: got %b want 0", i, ack_o);
      end
    end
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    access("load20 post-reset", 1'b0, 32'h20, 32'h0, rd, er);
    check_val("load20 after abort", rd, 32'h0BADF00D);
  endtask

  task automatic test_misalign();
    logic [31:0] rd;
    logic er;
    access("store22", 1'b1, 32'h22, 32'h00000001, rd, er);
`ifdef MISALIGN_CHECK_EN
    check_val("store22 err", {31'd0, er}, 32'd1);
`else
    check_val("store22 err", {31'd0, er}, 32'd0);
`endif
    access("load20 after 22", 1'b0, 32'h20, 32'h0, rd, er);
    check_val("load20 err", {31'd0, er}, 32'd0);
`ifdef MISALIGN_CHECK_EN
    check_val("load20 after misaligned store", rd, 32'h0BADF00D);
`else
    check_val("load20 after misaligned store", rd, 32'h00000001);
`endif
    access("load11", 1'b0, 32'h11, 32'h0, rd, er);
`ifdef MISALIGN_CHECK_EN
    check_val("load11 rdata", rd, 32'h0BADF00D);
    check_val("load11 err", {31'd0, er}, 32'd1);
`else
    check_val("load11 rdata", rd, 32'hDEADBEEF);
    check_val("load11 err", {31'd0, er}, 32'd0);
`endif
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic er;
    access("b2b store0", 1'b1, 32'h00, 32'hCAFEF00D, rd, er);
    access("b2b store7C", 1'b1, 32'h7C, 32'h55AA55AA, rd, er);
    access("b2b load0", 1'b0, 32'h00, 32'h0, rd, er);
    check_val("b2b load0", rd, 32'hCAFEF00D);
    access("b2b load7C", 1'b0, 32'h7C, 32'h0, rd, er);
    check_val("b2b load7C", rd, 32'h55AA55AA);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_wrap();
    test_reset_mid_access();
    test_misalign();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
